// File: rtl/delta_h_seq_if.sv
// Handshake and operand bus of the delta_h_seq hidden-layer delta unit.
// The master side drives operands and start; the slave side returns the result.
interface delta_h_seq_if #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32
);
  logic                   i_start;
  logic                   i_acc;
  logic [NUM*WIDTH-1:0]   i_prevd;
  logic [NUM*WIDTH-1:0]   i_w;
  logic [WIDTH-1:0]       i_act;
  logic [WIDTH-1:0]       o_delta;
  logic                   o_valid;
  logic                   o_busy;

  modport master (
    output i_start, i_acc, i_prevd, i_w, i_act,
    input  o_delta, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_acc, i_prevd, i_w, i_act,
    output o_delta, o_valid, o_busy
  );
endinterface

// File: rtl/delta_h_seq.sv
// Sequential hidden-layer delta: f'(a)*sum_k(delta_k*w_kj) on one shared multiplier.
// Define DELTA_H_SEQ_SAT_EN to saturate every intermediate instead of wrapping.
module delta_h_seq #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic          clk,
  input  logic          rst,
  delta_h_seq_if.slave  bus
);

  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [WIDTH-1:0] ONE_U    = WIDTH'(1) << FRAC;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_DERIV = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

`ifdef DELTA_H_SEQ_SAT_EN
  localparam logic signed [2*WIDTH-1:0] SAT_MAX =
    $signed({{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [2*WIDTH-1:0] SAT_MIN =
    $signed({{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
`endif

  // Full-precision signed product of two WIDTH-bit words.
  function automatic logic signed [2*WIDTH-1:0] mul_full(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    ax = $signed({{WIDTH{a[WIDTH-1]}}, a});
    bx = $signed({{WIDTH{b[WIDTH-1]}}, b});
    return ax * bx;
  endfunction

  // Drop FRAC bits with floor semantics, then fit back into WIDTH bits.
  function automatic logic signed [WIDTH-1:0] scale_fit(
    input logic signed [2*WIDTH-1:0] prod
  );
`ifdef DELTA_H_SEQ_SAT_EN
    logic signed [2*WIDTH-1:0] sh;
    sh = prod >>> FRAC;
    if (sh > SAT_MAX)
      return $signed(SAT_MAX[WIDTH-1:0]);
    else if (sh < SAT_MIN)
      return $signed(SAT_MIN[WIDTH-1:0]);
    else
      return $signed(sh[WIDTH-1:0]);
`else
    return WIDTH'(prod >>> FRAC);
`endif
  endfunction

  function automatic logic signed [WIDTH-1:0] add_fit(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
`ifdef DELTA_H_SEQ_SAT_EN
    logic signed [WIDTH:0] s;
    s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? $signed(SAT_MIN[WIDTH-1:0]) : $signed(SAT_MAX[WIDTH-1:0]);
    else
      return $signed(s[WIDTH-1:0]);
`else
    return a + b;
`endif
  endfunction

  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [NUM*WIDTH-1:0]     r_prevd_p0;
  logic [NUM*WIDTH-1:0]     r_w_p0;
  logic signed [WIDTH-1:0]  r_act_p0;
  logic                     r_accm_p0;
  logic signed [WIDTH-1:0]  r_acc_p1;
  logic signed [WIDTH-1:0]  r_deriv_p2;
  logic signed [WIDTH-1:0]  r_delta_p3;
  logic                     r_vld_p3;

  logic signed [WIDTH-1:0]  w_pd;
  logic signed [WIDTH-1:0]  w_wt;
  logic signed [WIDTH-1:0]  w_one_m_act;
  logic signed [WIDTH-1:0]  w_prod_fit;
  logic signed [WIDTH-1:0]  w_deriv;
  logic signed [WIDTH-1:0]  w_r;

  // Element select for the current MAC index.
  always_comb begin
    w_pd = '0;
    w_wt = '0;
    for (int k = 0; k < NUM; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_pd = $signed(r_prevd_p0[k*WIDTH +: WIDTH]);
        w_wt = $signed(r_w_p0[k*WIDTH +: WIDTH]);
      end
    end
  end

  // 1 - a is not a saturation point; it always wraps.
  assign w_one_m_act = $signed(ONE_U) - r_act_p0;
  assign w_prod_fit  = scale_fit(mul_full(w_pd, w_wt));
  assign w_deriv     = scale_fit(mul_full(r_act_p0, w_one_m_act));
  assign w_r         = scale_fit(mul_full(r_acc_p1, r_deriv_p2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_prevd_p0 <= '0;
      r_w_p0     <= '0;
      r_act_p0   <= '0;
      r_accm_p0  <= 1'b0;
      r_acc_p1   <= '0;
      r_deriv_p2 <= '0;
      r_delta_p3 <= '0;
      r_vld_p3   <= 1'b0;
    end else begin
      case (r_state)
        // p0: operands captured so callers may change inputs while busy
        S_IDLE: begin
          r_vld_p3 <= 1'b0;
          if (bus.i_start) begin
            r_prevd_p0 <= bus.i_prevd;
            r_w_p0     <= bus.i_w;
            r_act_p0   <= $signed(bus.i_act);
            r_accm_p0  <= bus.i_acc;
            r_acc_p1   <= '0;
            r_idx      <= '0;
            r_state    <= S_MAC;
          end
        end
        // p1: one delta*weight product folded into the sum per cycle
        S_MAC: begin
          r_acc_p1 <= add_fit(r_acc_p1, w_prod_fit);
          if (r_idx == LAST_IDX) begin
            r_state <= S_DERIV;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        // p2: sigmoid derivative on the shared multiplier
        S_DERIV: begin
          r_deriv_p2 <= w_deriv;
          r_state    <= S_DERIV + 2'd1;
        end
        // p3: final scale and optional accumulate into the held result
        S_OUT: begin
          r_delta_p3 <= r_accm_p0 ? add_fit(r_delta_p3, w_r) : w_r;
          r_vld_p3   <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_delta = r_delta_p3;
  assign bus.o_valid = r_vld_p3;
  assign bus.o_busy  = (r_state != S_IDLE);

endmodule

// File: doc/delta_h_seq.md
Name: delta_h_seq

Overview:
- Parametrised sequential hidden-layer delta unit for the backprop datapath.
- Computes delta_j = f'(a_j) * sum_k(delta_k * w_kj), where f'(a) = a*(1-a) is the sigmoid derivative.
- Uses one time-shared multiplier across NUM downstream neurons under a start/valid handshake.
- Optional batch accumulation: the new delta is added to the previous result.

Parameters:
- NUM, 4, number of downstream neurons (delta/weight pairs), >=1
- WIDTH, 32, signed fixed-point word width
- FRAC, 16, fractional bits; 1.0 = 2^FRAC

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- i_start  input  1  begin computation; sampled only in IDLE
- i_acc  input  1  sampled with i_start; 1 = add result to current o_delta, 0 = overwrite
- i_prevd  input  NUM*WIDTH  downstream deltas, element k at bits [k*WIDTH +: WIDTH]
- i_w  input  NUM*WIDTH  connecting weights, same packing
- i_act  input  WIDTH  activation a_j (sigmoid output, 0..1.0)
- o_delta  output  WIDTH  result; holds its value until the next completion
- o_valid  output  1  one-cycle pulse when o_delta is updated
- o_busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, o_delta=0, o_valid=0, o_busy=0, accumulator=0, index=0, all latches=0.
- i_start=1 in IDLE at edge E0:
  - Latch i_prevd, i_w, i_act and i_acc.
  - Clear the accumulator and index; go to MAC.
- MAC: one element per edge, k=0..NUM-1.
  - p = (prevd[k]*w[k]) >>> FRAC; full 2*WIDTH product, arithmetic shift (floor).
  - acc = acc + p; saturation/wrap rules below.
  - After k=NUM-1, go to DERIV.
- DERIV: deriv = (act*(ONE-act)) >>> FRAC, with ONE = 1<<FRAC; registered; go to OUT.
- OUT:
  - r = (acc*deriv) >>> FRAC.
  - o_delta <= (acc_mode ? o_delta + r : r).
  - o_valid <= 1 for exactly one cycle; go to IDLE.
- Latency: o_valid is high in the cycle after edge E(NUM+2).
  - Back-to-back: i_start may be high in the cycle o_valid is high (state is IDLE then).
  - Throughput: one result per NUM+3 cycles.
- i_start while o_busy=1 is ignored; inputs may change freely while busy because they are latched at E0.
- Arithmetic at every add/multiply is signed two's complement.
  - Default: every intermediate is truncated to WIDTH bits (wrap).
- Reset mid-operation aborts immediately to reset values; no o_valid is produced.
- i_act outside [0, 1.0] is computed as-is, with no clamping.
- NUM=1: MAC lasts one cycle.

Optional Feature:
- Macro DELTA_H_SEQ_SAT_EN.
- Defined: saturate to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1] at each of these points:
  - shifted product p
  - accumulator add
  - deriv
  - r
  - accumulate add into o_delta
- Undefined: plain WIDTH-bit truncation (wrap), no saturation logic synthesised.
- Timing and handshake are identical in both builds.

Test Plan (NUM=4, WIDTH=32, FRAC=16):
1. prevd all 0x00010000, w all 0x00008000, act 0x00008000, i_acc=0, pulse start -> o_valid high after 6th edge post-start; o_delta=0x00008000; o_busy high 6 cycles.
2. prevd[0]=0xFFFF0000 (-1.0), w[0]=0x00010000, others 0, act 0x00008000 -> o_delta=0xFFFFC000 (-0.25).
3. Run case 1, then case 1 again with i_acc=1 -> second o_delta=0x00010000. A third run with i_acc=0 -> 0x00008000.
4. act=0x00010000 (1.0), any nonzero prevd/w -> o_delta=0. Re-pulse start while busy -> ignored, exactly one o_valid.
5. Assert rst=0 during MAC of case 1 -> o_busy, o_valid and o_delta go 0 immediately, with no o_valid after release. A fresh start then gives 0x00008000.
6. With DELTA_H_SEQ_SAT_EN: prevd and w all 0x7FFF0000, act 0x00008000 -> acc saturates 0x7FFFFFFF; o_delta=0x1FFFFFFF.
